// File: rtl/gcd_serial_unit.sv
// Serial-load GCD engine: operands arrive one per cycle after a load strobe, then a
// subtractive (Euclid) or binary (Stein) iteration runs one step per cycle.
module gcd_serial_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ALGO  = 0,
   parameter int unsigned CNT_W = WIDTH + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] val_in,
   output logic [WIDTH-1:0] val_out,
   output logic             done,
   output logic             busy,
   output logic             zero_err,
   output logic [CNT_W-1:0] iter_cnt
);

   localparam int unsigned K_W = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      StIdle,
      StGetA,
      StGetB,
      StCalc,
      StFin
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CNT_W-1:0] iter_q, iter_d;
   logic             zerr_q, zerr_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         iter_q  <= '0;
         zerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         iter_q  <= iter_d;
         zerr_q  <= zerr_d;
      end
   end

   // Counter saturates so a long run never wraps to a misleading small value.
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      iter_d  = iter_q;
      zerr_d  = zerr_q;

      if (load) begin
         // A new load always wins: abandon whatever is running and clear results.
         state_d = StGetA;
         res_d   = '0;
         iter_d  = '0;
         zerr_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StIdle;
            end
            StGetA: begin
               a_d     = val_in;
               state_d = StGetB;
            end
            StGetB: begin
               b_d     = val_in;
               k_d     = '0;
               cnt_d   = '0;
               state_d = StCalc;
            end
            StCalc: begin
               cnt_d = cnt_inc;
               if (a_q == '0 || b_q == '0) begin
                  // Zero operands only exist on entry; the iterations never produce one.
                  res_d   = a_q | b_q;
                  zerr_d  = (a_q == '0) && (b_q == '0);
                  iter_d  = cnt_inc;
                  state_d = StFin;
               end else if (a_q == b_q) begin
                  res_d   = (ALGO == 0) ? a_q : (a_q << k_q);
                  iter_d  = cnt_inc;
                  state_d = StFin;
               end else if (ALGO == 0) begin
                  if (a_q > b_q) begin
                     a_d = a_q - b_q;
                  end else begin
                     b_d = b_q - a_q;
                  end
               end else begin
                  if (!a_q[0] && !b_q[0]) begin
                     a_d = a_q >> 1;
                     b_d = b_q >> 1;
                     k_d = k_q + K_W'(1);
                  end else if (!a_q[0]) begin
                     a_d = a_q >> 1;
                  end else if (!b_q[0]) begin
                     b_d = b_q >> 1;
                  end else if (a_q > b_q) begin
                     a_d = a_q - b_q;
                  end else begin
                     b_d = b_q - a_q;
                  end
               end
            end
            StFin: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   assign val_out  = res_q;
   assign iter_cnt = iter_q;
   assign zero_err = zerr_q;
   assign done     = (state_q == StFin);
   assign busy     = (state_q == StGetA) || (state_q == StGetB) || (state_q == StCalc);

endmodule

// File: doc/gcd_serial_unit.md
Name: gcd_serial_unit

Overview:
- Parametrised successor to the 8-bit serial-load GCD thread.
- Accepts two unsigned operands over a shared input bus after a load strobe, then computes their GCD.
- Generalised in width, with a selectable subtractive or binary (Stein) algorithm.
- Adds a busy flag, zero-operand handling, abort-on-reload and an iteration counter; used as the GCD compute thread in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (2..32).
- ALGO, 0, 0 = subtractive Euclid; 1 = binary Stein.
- CNT_W, WIDTH+1, width of the iteration counter output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  start strobe; sampled high for one cycle.
- val_in  in  WIDTH  operand bus: A in the cycle after load, B in the cycle after that.
- val_out  out  WIDTH  GCD result; held until the next load.
- done  out  1  one-cycle pulse when val_out becomes valid.
- busy  out  1  high from the cycle after load until done.
- zero_err  out  1  set with done when A = B = 0.
- iter_cnt  out  CNT_W  CALC cycles used by the last operation; held with val_out.

Behaviour:
- Reset (rst low, asynchronous):
  - Every output goes to 0 and the FSM goes to IDLE.
  - A mid-operation reset aborts the operation with no done pulse.
- FSM states: IDLE, GET_A, GET_B, CALC, FIN.
  - IDLE: stays until load = 1, then goes to GET_A.
  - GET_A: registers a <= val_in, then goes to GET_B.
  - GET_B: registers b <= val_in, clears k and the counter, then goes to CALC.
  - CALC: one algorithm step per cycle; the counter increments each CALC cycle and saturates at all-ones.
  - FIN: drives done = 1 for exactly one cycle, then returns to IDLE.
- busy = 1 in GET_A, GET_B and CALC; busy = 0 in IDLE and FIN.
- load is honoured in every state, FIN included.
  - It aborts any operation in progress and goes to GET_A on the next edge.
  - No done pulse is produced for the aborted operation.
  - val_out, iter_cnt and zero_err are cleared on load.
- Zero rules, checked on the first CALC cycle, which counts as one iteration:
  - a = 0, b = 0: result 0, zero_err = 1.
  - a = 0, b != 0: result b.
  - a != 0, b = 0: result a.
  - In all three cases the FSM goes to FIN.
- ALGO = 0, one CALC step:
  - a == b: result a, go to FIN.
  - a > b: a <= a - b.
  - a < b: b <= b - a.
- ALGO = 1, one CALC step, first matching rule applies:
  - a == b: result a << k, go to FIN.
  - Both even: shift both right by 1, k++.
  - a even: a >> 1.
  - b even: b >> 1.
  - Otherwise: subtract the smaller from the larger.
- k is clog2(WIDTH)+1 bits wide. The result is truncated to WIDTH bits and is mathematically exact.
- Result registers (val_out, iter_cnt, zero_err) update on the CALC-to-FIN edge, so they are valid in the same cycle done is high.
- Latency from the load cycle is 3 + n cycles to done, where n = iter_cnt.
- Operands are all-unsigned. No overflow is possible: subtraction is always larger minus smaller.

Test Plan:
- ALGO = 0, WIDTH = 8: load, A = 8, B = 20 -> done, val_out = 4, iter_cnt = 4, zero_err = 0, done 7 cycles after load.
- ALGO = 0, WIDTH = 8: (18, 45), then (28, 49), issued back-to-back -> val_out = 9, then 7; one done pulse each; busy low between operations.
- ALGO = 1, WIDTH = 16: (48, 180) -> val_out = 12.
- ALGO = 1, WIDTH = 16: (65535, 65535) -> val_out = 65535, iter_cnt = 1.
- Zero cases: (0, 0) -> val_out = 0, zero_err = 1, iter_cnt = 1. (0, 35) -> val_out = 35, zero_err = 0.
- Abort and reset:
  - Start (1, 255) with ALGO = 0, then load again at CALC cycle 10 with (6, 9) -> single done, val_out = 3.
  - Then start another operation and drop rst mid-CALC -> all outputs 0 immediately, no done pulse.
